// File: rtl/prb_pkg.sv
// Shared types and helpers for the progressive-precision early-termination controller.
// Holds the controller state encoding and the RNG index bit-reversal helper.
package prb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } prb_state_t;

    localparam int PRB_MAXW = 32;

    // Reverses the low w bits of v; callers truncate the result to w bits.
    function automatic logic [PRB_MAXW-1:0] bitrev(input logic [PRB_MAXW-1:0] v, input int w);
        logic [PRB_MAXW-1:0] r;
        r = {<<{v}};
        return r >> (PRB_MAXW - w);
    endfunction

endpackage

// File: rtl/tzd.sv
// Trailing-zero detector: index of the lowest set bit of vec, or W when vec is all zero.
module tzd #(
    parameter int W = 8
) (
    input  logic [W-1:0]             vec,
    output logic [$clog2(W+1)-1:0]   tz
);

    localparam int TZW = $clog2(W+1);

    // Scan from MSB down so the lowest set bit is the last one to win.
    always_comb begin
        tz = TZW'(W);
        for (int i = W - 1; i >= 0; i--) begin
            tz = vec[i] ? TZW'(i) : tz;
        end
    end

endmodule

// File: rtl/prb_et_ctrl.sv
// Early-termination sequencer: derives the shortest exact stream length for an operand group
// and walks a bit-reversed RNG index over it, emitting one comparator bit per operand per beat.
module prb_et_ctrl
    import prb_pkg::*;
#(
    parameter int W = 8,
    parameter int N = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  Bxs [N-1:0],
    input  logic          abort,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_bits,
    output logic          out_last,
    output logic [W:0]    len,
    output logic [W-1:0]  cnt
);

    localparam int TZW = $clog2(W+1);

    prb_state_t         state_r;
    logic [W-1:0]       bx_q_r [N-1:0];
    logic [W-1:0]       cnt_r;
    logic [W:0]         len_r;

    logic [W-1:0]       or_s;
    logic [TZW-1:0]     tz_s;
    logic [W:0]         len_next_s;
    logic [W-1:0]       rng_s;
    logic               run_s;
    logic               last_s;

    // OR-reduce the incoming group; its trailing zeros set the exact stream length.
    always_comb begin
        or_s = {W{1'b0}};
        for (int j = 0; j < N; j++) begin
            or_s = or_s | Bxs[j];
        end
    end

    tzd #(.W(W)) u_tzd (
        .vec (or_s),
        .tz  (tz_s)
    );

    assign len_next_s = {{W{1'b0}}, 1'b1} << (TZW'(W) - tz_s);
    assign run_s      = (state_r == RUN);
    assign rng_s      = W'(bitrev(PRB_MAXW'(cnt_r), W));
    assign last_s     = run_s && ({1'b0, cnt_r} == (len_r - {{W{1'b0}}, 1'b1}));

    // Accept/run state machine with beat counter; len survives abort and completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {W{1'b0}};
            len_r   <= {(W+1){1'b0}};
            for (int j = 0; j < N; j++) begin
                bx_q_r[j] <= {W{1'b0}};
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        bx_q_r  <= Bxs;
                        len_r   <= len_next_s;
                        cnt_r   <= {W{1'b0}};
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    if (out_ready && last_s) begin
                        state_r <= IDLE;
                        cnt_r   <= {W{1'b0}};
                    end else if (abort) begin
                        state_r <= IDLE;
                        cnt_r   <= {W{1'b0}};
                    end else if (out_ready) begin
                        cnt_r   <= cnt_r + {{(W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {W{1'b0}};
                end
            endcase
        end
    end

    // Parallel comparators against the shared RNG value, forced low outside RUN.
    always_comb begin
        out_bits = {N{1'b0}};
        for (int j = 0; j < N; j++) begin
            out_bits[j] = run_s && (bx_q_r[j] > rng_s);
        end
    end

    assign in_ready  = !run_s;
    assign out_valid = run_s;
    assign out_last  = last_s;
    assign len       = len_r;
    assign cnt       = cnt_r;

endmodule

// File: tb/tb_prb_et_ctrl.sv
// Self-checking bench for prb_et_ctrl (W=4, N=2): directed scenarios plus randomized groups
// compared against an arithmetic reference model of the stream rules.
module tb_prb_et_ctrl;

    localparam int W = 4;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  bxs [N-1:0];
    logic          abort = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [N-1:0]  out_bits;
    logic          out_last;
    logic [W:0]    len;
    logic [W-1:0]  cnt;

    int vectors = 0;
    int miscompares = 0;

    prb_et_ctrl #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Bxs       (bxs),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bits  (out_bits),
        .out_last  (out_last),
        .len       (len),
        .cnt       (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: reverse the W-bit index by peeling binary digits arithmetically.
    function automatic int ref_rev(input int k);
        int r, x;
        r = 0;
        x = k;
        for (int i = 0; i < W; i++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    function automatic int ref_tz(input int v);
        int t;
        t = 0;
        while (t < W && (v % 2) == 0) begin
            v = v / 2;
            t++;
        end
        return t;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_bits"}, 32'(out_bits), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_len"}, 32'(len), 32'd0);
        chk({tag, "_cnt"}, 32'(cnt), 32'd0);
    endtask

    // One group from IDLE to IDLE; called and returning at a falling edge.
    task automatic run_group(input int b0, input int b1, input int rdy_pct,
                             input int stall_k, input int stall_n, input int abort_k,
                             input int rst_k, input bit poke);
        int tz, l, k, cyc, stalls, pc0, pc1, e0, e1;
        bit done, full, rdy, ab, was_reset;
        tz = ref_tz(b0 | b1);
        l = 1 << (W - tz);
        k = 0; cyc = 0; stalls = 0; pc0 = 0; pc1 = 0;
        done = 1'b0; full = 1'b0; was_reset = 1'b0;

        abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_in_ready", 32'(in_ready), 32'd1);
        chk("idle_abort_out_valid", 32'(out_valid), 32'd0);
        abort = 1'b0;
        in_valid = 1'b1;
        bxs[0] = 4'(b0);
        bxs[1] = 4'(b1);
        @(negedge clk);
        if (poke) begin
            bxs[0] = 4'd15;
            bxs[1] = 4'd15;
        end else begin
            in_valid = 1'b0;
        end

        while (!done && !was_reset && cyc < 400) begin
            e0 = (b0 > ref_rev(k)) ? 1 : 0;
            e1 = (b1 > ref_rev(k)) ? 1 : 0;
            chk("run_out_valid", 32'(out_valid), 32'd1);
            chk("run_in_ready", 32'(in_ready), 32'd0);
            chk("run_cnt", 32'(cnt), 32'(k));
            chk("run_len", 32'(len), 32'(l));
            chk("run_out_last", 32'(out_last), (k == l - 1) ? 32'd1 : 32'd0);
            chk("run_out_bits", 32'(out_bits), 32'(e1 * 2 + e0));
            if (k == rst_k) begin
                out_ready = 1'b0;
                #2 rst_n = 1'b0;
                #1 chk_reset_vals("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
                was_reset = 1'b1;
            end else begin
                rdy = ($urandom_range(0, 99) < rdy_pct);
                if (k == stall_k && stalls < stall_n) begin
                    rdy = 1'b0;
                    stalls++;
                end
                ab = (k == abort_k);
                out_ready = rdy;
                abort = ab;
                @(negedge clk);
                cyc++;
                if (rdy) begin
                    pc0 += e0;
                    pc1 += e1;
                end
                if (rdy && k == l - 1) begin
                    done = 1'b1;
                    full = 1'b1;
                end else if (ab) begin
                    done = 1'b1;
                end else if (rdy) begin
                    k++;
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        abort = 1'b0;

        if (!was_reset) begin
            if (!done) chk("run_timeout", 32'd0, 32'd1);
            chk("end_out_valid", 32'(out_valid), 32'd0);
            chk("end_in_ready", 32'(in_ready), 32'd1);
            chk("end_out_last", 32'(out_last), 32'd0);
            chk("end_out_bits", 32'(out_bits), 32'd0);
            chk("end_len", 32'(len), 32'(l));
            chk("end_cnt", 32'(cnt), 32'd0);
            if (full) begin
                chk("popcount_lane0", 32'(pc0), 32'(b0 >> tz));
                chk("popcount_lane1", 32'(pc1), 32'(b1 >> tz));
            end
        end
    endtask

    initial begin
        bxs[0] = 4'd0;
        bxs[1] = 4'd0;
        repeat (2) @(negedge clk);
        chk_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_reset_idle");

        // lane0=8, lane1=4: len 4, rng 0,8,4,12.
        run_group(8, 4, 100, -1, 0, -1, -1, 1'b0);
        // all-zero group: single beat, bits 00, out_last.
        run_group(0, 0, 100, -1, 0, -1, -1, 1'b0);
        // lane0=1, lane1=15: len 16, popcounts 1 and 15.
        run_group(1, 15, 100, -1, 0, -1, -1, 1'b0);
        // len 4 with three stall cycles at cnt=2.
        run_group(8, 4, 100, 2, 3, -1, -1, 1'b0);
        // len 8 aborted at cnt=1, in_valid held high during RUN.
        run_group(2, 6, 100, -1, 0, 1, -1, 1'b1);
        // new group accepted normally after abort.
        run_group(12, 3, 100, -1, 0, -1, -1, 1'b0);
        // abort coinciding with the last transfer.
        run_group(4, 8, 100, -1, 0, 3, -1, 1'b0);
        // async reset at cnt=5 of a len 16 run, then a fresh group.
        run_group(6, 9, 100, -1, 0, -1, 5, 1'b0);
        run_group(10, 5, 100, -1, 0, -1, -1, 1'b0);

        for (int g = 0; g < 24; g++) begin
            run_group(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(30, 100)), -1, 0,
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                      -1, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
